// File: rtl/tmr0_wdt_pkg.sv
// Shared constants and helpers for the TMR0 / watchdog sequencer.
package tmr0_wdt_pkg;

    localparam int OPT_T0CS   = 5;
    localparam int OPT_T0SE   = 4;
    localparam int OPT_PSA    = 3;
    localparam int OPT_PS_MSB = 2;

    localparam logic [5:0] OPTION_RST     = 6'h3F;
    localparam int         WDT_PERIOD_DEF = 1024;

    typedef enum logic {
        SRC_INTERNAL = 1'b0,
        SRC_T0CKI    = 1'b1
    } clk_src_e;

    // Bits prescaler[PS:0]: TMR0 wraps every 2^(PS+1) ticks.
    function automatic logic [7:0] tmr_mask(input logic [2:0] ps);
        return 8'hFF >> (3'd7 - ps);
    endfunction

    // Bits prescaler[PS-1:0]: empty for PS=0, so every base tick times out.
    function automatic logic [7:0] wdt_mask(input logic [2:0] ps);
        return tmr_mask(ps) >> 1;
    endfunction

endpackage

// File: rtl/tmr0_wdt_ctrl_t0cki_edge_sync.sv
// Two-flop synchronizer for the T0CKI pin followed by a registered edge pulse.
module t0cki_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic t0cki,
    input  logic fall_sel,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic prev;
    logic edge_raw;

    assign edge_raw = fall_sel ? (prev & ~sync2) : (~prev & sync2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync1      <= t0cki;
            sync2      <= sync1;
            prev       <= sync2;
            edge_pulse <= edge_raw;
        end
    end

endmodule

// File: rtl/tmr0_wdt_ctrl.sv
// TMR0 tick / watchdog sequencer with a shared 8-bit prescaler.
// Watchdog, timeout and sleep/wake logic exist only when WDT_EN is defined.
module tmr0_wdt_ctrl
    import tmr0_wdt_pkg::*;
#(
    parameter int WDT_PERIOD = WDT_PERIOD_DEF,
    parameter int WDT_CW     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       option_wr,
    input  logic [5:0] option_in,
    input  logic       tmr0_wr,
    input  logic       clrwdt,
    input  logic       sleep,
    input  logic       t0cki,
    output logic [5:0] option_out,
    output logic       tmr0_inc,
    output logic       wdtmr,
    output logic       sleeping,
    output logic       wake
);

    logic [5:0] option_q;
    logic [7:0] prescaler;
    logic [7:0] pre_next;
    logic [2:0] ps;
    logic       psa;
    logic       inhibit;
    logic       ext_edge;
    logic       tick;
    logic       psa_change;
    logic       wdt_clr;
    logic       pre_clear;
    logic       pre_inc;
    logic       tmr_wrap;
    clk_src_e   src;

    assign option_out = option_q;
    assign psa        = option_q[OPT_PSA];
    assign ps         = option_q[OPT_PS_MSB:0];
    assign src        = clk_src_e'(option_q[OPT_T0CS]);

    t0cki_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .t0cki      (t0cki),
        .fall_sel   (option_q[OPT_T0SE]),
        .edge_pulse (ext_edge)
    );

    assign tick       = (src == SRC_T0CKI) ? ext_edge : ~sleeping;
    assign pre_next   = prescaler + 8'd1;
    assign psa_change = option_wr & (option_in[OPT_PSA] != psa);
    assign pre_clear  = psa_change | (tmr0_wr & ~psa) | (wdt_clr & psa);

`ifdef WDT_EN
    logic [WDT_CW-1:0] base_cnt;
    logic              base_tick;
    logic              timeout;

    assign wdt_clr   = clrwdt | sleep;
    assign base_tick = (base_cnt == WDT_CW'(WDT_PERIOD - 1));
    assign pre_inc   = ~option_wr & (psa ? base_tick : tick);
    assign timeout   = ~wdt_clr &
                       (psa ? (pre_inc & ((pre_next & wdt_mask(ps)) == 8'd0)) : base_tick);

    // A timeout during sleep ends it; a new SLEEP strobe takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_cnt <= '0;
            wdtmr    <= 1'b0;
            wake     <= 1'b0;
            sleeping <= 1'b0;
        end else begin
            base_cnt <= wdt_clr ? '0 : base_cnt + WDT_CW'(1);
            wdtmr    <= timeout;
            wake     <= timeout & sleeping;
            if (sleep)
                sleeping <= 1'b1;
            else if (timeout)
                sleeping <= 1'b0;
        end
    end
`else
    logic unused_strobes;

    assign unused_strobes = clrwdt ^ sleep;
    assign wdt_clr        = 1'b0;
    assign pre_inc        = ~option_wr & ~psa & tick;
    assign wdtmr          = 1'b0;
    assign wake           = 1'b0;
    assign sleeping       = 1'b0;
`endif

    assign tmr_wrap = ~psa & pre_inc & ((pre_next & tmr_mask(ps)) == 8'd0);

    // Ticks landing in the TMR0 write cycle or the one after are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            option_q  <= OPTION_RST;
            prescaler <= 8'd0;
            inhibit   <= 1'b0;
            tmr0_inc  <= 1'b0;
        end else begin
            if (option_wr)
                option_q <= option_in;
            if (pre_clear)
                prescaler <= 8'd0;
            else if (pre_inc)
                prescaler <= pre_next;
            inhibit  <= tmr0_wr;
            tmr0_inc <= (psa ? tick : tmr_wrap) & ~tmr0_wr & ~inhibit;
        end
    end

endmodule

// File: tb/tb_tmr0_wdt_ctrl.sv
// Scoreboard bench for tmr0_wdt_ctrl: expected pulse cycles are queued as
// stimulus is applied and consumed as the DUT pulses. Watchdog cases need WDT_EN.
module tb_tmr0_wdt_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       option_wr = 1'b0;
    logic [5:0] option_in = 6'h00;
    logic       tmr0_wr   = 1'b0;
    logic       clrwdt    = 1'b0;
    logic       sleep     = 1'b0;
    logic       t0cki     = 1'b0;
    logic [5:0] option_out;
    logic       tmr0_inc;
    logic       wdtmr;
    logic       sleeping;
    logic       wake;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int exp_inc[$];
    int exp_wdt[$];
    int exp_wake[$];
    bit mon_inc  = 1'b0;
    bit mon_wdt  = 1'b0;
    int w;
    int s;
    int c;

    tmr0_wdt_ctrl #(.WDT_PERIOD(16), .WDT_CW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .option_wr  (option_wr),
        .option_in  (option_in),
        .tmr0_wr    (tmr0_wr),
        .clrwdt     (clrwdt),
        .sleep      (sleep),
        .t0cki      (t0cki),
        .option_out (option_out),
        .tmr0_inc   (tmr0_inc),
        .wdtmr      (wdtmr),
        .sleeping   (sleeping),
        .wake       (wake)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Compare each output pulse against the front of its expectation queue.
    task automatic monitor();
        if (mon_inc) begin
            if (tmr0_inc) begin
                if (exp_inc.size() == 0) checkOutput($sformatf("inc_unexp@%0d", cyc), int'(tmr0_inc), 0);
                else checkOutput("inc_cycle", cyc, exp_inc.pop_front());
            end else if (exp_inc.size() != 0 && exp_inc[0] <= cyc) begin
                checkOutput($sformatf("inc_missed@%0d", exp_inc.pop_front()), int'(tmr0_inc), 1);
            end
        end
        if (mon_wdt) begin
            if (wdtmr) begin
                if (exp_wdt.size() == 0) checkOutput($sformatf("wdt_unexp@%0d", cyc), int'(wdtmr), 0);
                else checkOutput("wdt_cycle", cyc, exp_wdt.pop_front());
            end else if (exp_wdt.size() != 0 && exp_wdt[0] <= cyc) begin
                checkOutput($sformatf("wdt_missed@%0d", exp_wdt.pop_front()), int'(wdtmr), 1);
            end
            if (wake) begin
                if (exp_wake.size() == 0) checkOutput($sformatf("wake_unexp@%0d", cyc), int'(wake), 0);
                else checkOutput("wake_cycle", cyc, exp_wake.pop_front());
            end else if (exp_wake.size() != 0 && exp_wake[0] <= cyc) begin
                checkOutput($sformatf("wake_missed@%0d", exp_wake.pop_front()), int'(wake), 1);
            end
        end
    endtask

    task automatic tick_cycle();
        @(negedge clk);
        monitor();
    endtask

    task automatic run(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic applyStimulus(input logic o_wr, input logic [5:0] o_val,
                                 input logic t_wr, input logic c_wdt, input logic slp);
        option_wr = o_wr;
        option_in = o_val;
        tmr0_wr   = t_wr;
        clrwdt    = c_wdt;
        sleep     = slp;
        tick_cycle();
        option_wr = 1'b0;
        tmr0_wr   = 1'b0;
        clrwdt    = 1'b0;
        sleep     = 1'b0;
    endtask

    task automatic write_option(input logic [5:0] v);
        applyStimulus(1'b1, v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic finish_window();
        checkOutput("inc_left", exp_inc.size(), 0);
        checkOutput("wdt_left", exp_wdt.size(), 0);
        checkOutput("wake_left", exp_wake.size(), 0);
        exp_inc.delete();
        exp_wdt.delete();
        exp_wake.delete();
        mon_inc = 1'b0;
        mon_wdt = 1'b0;
    endtask

    initial begin
        run(3);
        checkOutput("rst_option", int'(option_out), 'h3F);
        checkOutput("rst_outputs", int'({tmr0_inc, wdtmr, wake, sleeping}), 0);
        rst_n = 1'b1;
        run(2);

        $display("[TB] internal clock, PSA=0, PS=0");
        mon_inc = 1'b1;
        w = cyc + 1;
        for (int i = 2; i <= 12; i += 2) exp_inc.push_back(w + i);
        write_option(6'h00);
        run(12);
        checkOutput("opt_readback", int'(option_out), 'h00);
        finish_window();

        $display("[TB] PS=3 with TMR0 write mid-count");
        write_option(6'h03);
        run(7);
        mon_inc = 1'b1;
        w = cyc + 1;
        exp_inc.push_back(w + 16);
        exp_inc.push_back(w + 32);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        run(32);
        finish_window();

        $display("[TB] unscaled TMR0 with write inhibit");
        write_option(6'h08);
        run(3);
        mon_inc = 1'b1;
        w = cyc + 1;
        for (int i = 2; i <= 8; i++) exp_inc.push_back(w + i);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        run(8);
        finish_window();

        $display("[TB] external clock, falling edge");
        write_option(6'h38);
        run(4);
        mon_inc = 1'b1;
        for (int p = 0; p < 3; p++) begin
            t0cki = 1'b1;
            run(5);
            t0cki = 1'b0;
            exp_inc.push_back(cyc + 4);
            run(5);
        end
        finish_window();

        $display("[TB] external clock, rising edge");
        write_option(6'h28);
        run(4);
        mon_inc = 1'b1;
        t0cki = 1'b1;
        exp_inc.push_back(cyc + 4);
        run(6);
        t0cki = 1'b0;
        run(6);
        finish_window();

`ifdef WDT_EN
        $display("[TB] watchdog PSA=1 PS=2 with CLRWDT");
        write_option(6'h0A);
        run(3);
        mon_wdt = 1'b1;
        c = cyc + 1;
        exp_wdt.push_back(c + 64);
        exp_wdt.push_back(c + 128);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        run(187);
        exp_wdt.push_back(cyc + 1 + 64);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        run(64);
        finish_window();

        $display("[TB] sleep and watchdog wake");
        write_option(6'h03);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        mon_inc = 1'b1;
        mon_wdt = 1'b1;
        s = cyc + 1;
        exp_inc.push_back(s + 30);
        exp_wdt.push_back(s + 16);
        exp_wdt.push_back(s + 32);
        exp_wake.push_back(s + 16);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("sleeping_set", int'(sleeping), 1);
        run(15);
        checkOutput("sleeping_hold", int'(sleeping), 1);
        run(1);
        checkOutput("sleeping_clear", int'(sleeping), 0);
        run(17);
        finish_window();
`else
        $display("[TB] sleep and CLRWDT ignored without watchdog");
        mon_inc = 1'b1;
        mon_wdt = 1'b1;
        w = cyc + 1;
        exp_inc.push_back(w + 16);
        exp_inc.push_back(w + 32);
        write_option(6'h03);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("sleeping_tied", int'(sleeping), 0);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        run(31);
        checkOutput("sleeping_tied_end", int'(sleeping), 0);
        finish_window();
`endif

        $display("[TB] asynchronous reset mid-count");
        write_option(6'h08);
        run(3);
        checkOutput("pre_rst_inc", int'(tmr0_inc), 1);
        checkOutput("pre_rst_opt", int'(option_out), 'h08);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_opt", int'(option_out), 'h3F);
        checkOutput("async_rst_inc", int'(tmr0_inc), 0);
        checkOutput("async_rst_wdt", int'({wdtmr, wake, sleeping}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmr0_wdt_ctrl.md
Name: tmr0_wdt_ctrl

Overview:
Timer/watchdog sequencer that drives the register file's tmr0_inc and wdtmr inputs.
- Holds the 6-bit OPTION register.
- Selects the TMR0 clock source: internal cycle or external T0CKI edge.
- Shares one 8-bit prescaler between TMR0 and the watchdog.
- Tracks sleep state and raises a wake pulse on watchdog timeout.
- Sits beside the register file; fed by decoder strobes (OPTION write, TMR0 write, CLRWDT, SLEEP).

Parameters:
WDT_PERIOD, 1024, clk cycles per watchdog base tick (power of two, min 4)
WDT_CW, 10, width of the base counter, equal to log2(WDT_PERIOD)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
option_wr  in  1  load OPTION from option_in this cycle
option_in  in  6  {T0CS, T0SE, PSA, PS[2:0]}
tmr0_wr  in  1  register-file write to the TMR0 address, same cycle as the write
clrwdt  in  1  CLRWDT instruction strobe
sleep  in  1  SLEEP instruction strobe
t0cki  in  1  asynchronous external timer pin
option_out  out  6  current OPTION value
tmr0_inc  out  1  one-cycle increment pulse to TMR0
wdtmr  out  1  one-cycle watchdog timeout pulse
sleeping  out  1  high from the cycle after sleep until wake
wake  out  1  one-cycle pulse when a timeout ends sleep

Behaviour:
- Reset, asynchronous on rst_n low. Values:
  - OPTION = 6'b111111.
  - Prescaler = 0, WDT base counter = 0, sync flops = 0, inhibit = 0.
  - tmr0_inc = 0, wdtmr = 0, wake = 0, sleeping = 0.
- All other state updates on posedge clk. All outputs are registered.
- Tick source:
  - T0CS=0: a tick on every cycle in which sleeping=0.
  - T0CS=1: t0cki passes a 2-flop synchronizer plus an edge register. The active edge is rising when T0SE=0 and falling when T0SE=1. Ticks continue during sleep.
- PSA=0 (prescaler on TMR0):
  - Each tick increments the prescaler.
  - tmr0_inc pulses on the cycle after prescaler[PS:0] wraps to zero, i.e. every 2^(PS+1) ticks.
- PSA=1 (prescaler on WDT):
  - tmr0_inc pulses on the cycle after each tick.
  - External-edge latency from t0cki to tmr0_inc is 4 cycles.
- TMR0 write inhibit:
  - tmr0_wr clears the prescaler when PSA=0.
  - tmr0_wr suppresses tmr0_inc in the write cycle and the next cycle. Ticks in those two cycles are dropped, not deferred.
- Watchdog base counter:
  - Free-runs on clk, including during sleep.
  - Produces a base tick when it wraps at WDT_PERIOD-1 to 0.
  - PSA=0: every base tick is a timeout.
  - PSA=1: base ticks increment the prescaler; a timeout occurs when the tick makes prescaler[PS-1:0] all zero (PS=0 means every base tick).
- Timeout output: wdtmr pulses for 1 cycle on the cycle after the timeout.
- clrwdt or sleep:
  - Clears the base counter.
  - Clears the prescaler if PSA=1.
  - Wins over a coincident timeout; no wdtmr is issued that cycle.
- Sleep state:
  - sleep sets sleeping the next cycle.
  - A timeout while sleeping=1 clears sleeping and pulses wake in the same cycle as wdtmr.
- OPTION writes:
  - option_wr updates OPTION the next cycle.
  - If the PSA bit changes, the prescaler clears in the same edge.
  - option_wr wins over a coincident prescaler increment.
- Priority on the prescaler: clears (PSA change, tmr0_wr with PSA=0, clrwdt/sleep with PSA=1) > increment.

Optional Feature:
Macro WDT_EN.
- Defined: watchdog counter, timeout, and wake logic present as above.
- Undefined:
  - Base counter removed; wdtmr, wake and sleeping are tied to 0.
  - clrwdt and sleep are ignored.
  - PSA=1 means TMR0 runs unscaled and the prescaler is held at 0.

Decomposition:
Package tmr0_wdt_pkg holds:
- OPTION bit index constants: OPT_T0CS=5, OPT_T0SE=4, OPT_PSA=3, OPT_PS_MSB=2.
- OPTION_RST = 6'h3F.
- Default WDT_PERIOD.

One sub-module, t0cki_edge_sync: 2-flop synchronizer plus edge register, with the polarity select as input and a one-cycle edge pulse as output.

Test Plan:
- Reset, then option_wr 6'b000000 (internal clock, PSA=0, PS=0) -> tmr0_inc every 2nd cycle; option_out reads 6'h00.
- PS=3, PSA=0, tmr0_wr asserted mid-count -> prescaler restarts; no tmr0_inc for 2 cycles, then the next pulse comes 16 ticks after the write.
- T0CS=1, T0SE=1, PSA=1; toggle t0cki with period 10 cycles -> tmr0_inc 4 cycles after each falling edge, none on rising edges.
- WDT_PERIOD=16, PSA=1, PS=2; no clrwdt -> wdtmr every 64 cycles. clrwdt at cycle 60 -> next wdtmr at cycle 124.
- sleep strobe with PSA=0, WDT_PERIOD=16 -> sleeping=1 the next cycle; internal tmr0_inc stops; wdtmr and wake pulse together 16 cycles after sleep; sleeping returns to 0.
- rst_n pulsed low mid-count, asynchronous to clk -> all outputs 0 and OPTION=6'h3F immediately, without waiting for a clock edge.
